// File: rtl/core_types_pkg.sv
// Shared core types for the fetch stage.
//   word_t        : 32-bit machine word / address
//   fetch_state_t : fetch FSM states (FETCH, STOPPED, HALTED)
//   iq_entry_t    : instruction-queue entry {pc, instr}
//   HALT_INSTR_DEFAULT : encoding that stops fetch
package core_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STOPPED = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } iq_entry_t;

    localparam word_t HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> icache blocking read interface.
//   icache_REN  : read request (fetch -> icache)
//   icache_addr : word address, bits [1:0] zero (fetch -> icache)
//   icache_halt : halt indication (fetch -> icache)
//   icache_hit  : response valid this cycle (icache -> fetch)
//   icache_load : instruction word, valid with icache_hit (icache -> fetch)
// Modports: master = fetch side, slave = icache side.
interface fetch_unit_if;

    logic                        icache_REN;
    core_types_pkg::word_t       icache_addr;
    logic                        icache_halt;
    logic                        icache_hit;
    core_types_pkg::word_t       icache_load;

    modport master (
        output icache_REN,
        output icache_addr,
        output icache_halt,
        input  icache_hit,
        input  icache_load
    );

    modport slave (
        input  icache_REN,
        input  icache_addr,
        input  icache_halt,
        output icache_hit,
        output icache_load
    );

endinterface

// File: rtl/fetch_iq.sv
// Instruction queue: circular FIFO of iq_entry_t.
//   CLK, RST  : clock, synchronous active-high reset
//   flush     : empties the queue next cycle (overrides push/pop)
//   push      : enqueue push_data (ignored when full)
//   pop       : dequeue head (ignored when empty)
//   head      : current head entry
//   full/empty: decided on the current occupancy only
module fetch_iq
    import core_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      flush,
    input  logic      push,
    input  iq_entry_t push_data,
    input  logic      pop,
    output iq_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    iq_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[head_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[tail_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the icache blocking read interface, queues
// fetched instructions in fetch_iq and presents them to decode (valid/ready).
// Handles redirects, HALT_INSTR detection and forwards core halt to the icache.
// Ports:
//   CLK, RST                     : clock, synchronous active-high reset
//   icache (fetch_unit_if.master): REN/addr/halt out, hit/load in
//   redirect_valid, redirect_pc  : PC redirect from execute/commit
//   core_halt                    : core has committed HALT
//   dec_valid/dec_instr/dec_pc   : IQ head (or bypassed word) to decode
//   dec_ready                    : decode accepts head this cycle
//   fetch_stopped                : fetch stopped after issuing HALT_INSTR
// Optional: define FETCH_BYPASS_EN to forward a hit straight to decode when
// the IQ is empty (zero-cycle fetch-to-decode).
module fetch_unit
    import core_types_pkg::*;
#(
    parameter int unsigned IQ_DEPTH   = 4,
    parameter word_t       RESET_PC   = 32'h0000_0000,
    parameter word_t       HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    fetch_unit_if.master        icache,
    input  logic                redirect_valid,
    input  word_t               redirect_pc,
    input  logic                core_halt,
    output logic                dec_valid,
    output word_t               dec_instr,
    output word_t               dec_pc,
    input  logic                dec_ready,
    output logic                fetch_stopped
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;

    logic      iq_full, iq_empty, iq_push, iq_pop;
    iq_entry_t iq_head;

    logic fetch_req, fire, is_halt, redirect_take, bypass;

    // Low PC bits are always forced to zero.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Halt beats redirect; redirect is dead once halted.
    assign redirect_take = redirect_valid & ~core_halt & (state_q != HALTED);

    assign fetch_req = (state_q == FETCH) & ~iq_full & ~redirect_valid;
    assign fire      = fetch_req & icache.icache_hit;
    assign is_halt   = (icache.icache_load == HALT_INSTR);

`ifdef FETCH_BYPASS_EN
    assign bypass    = fire & iq_empty;
    assign dec_valid = ~iq_empty | bypass;
    assign dec_instr = iq_empty ? icache.icache_load : iq_head.instr;
    assign dec_pc    = iq_empty ? pc_q : iq_head.pc;
`else
    assign bypass    = 1'b0;
    assign dec_valid = ~iq_empty;
    assign dec_instr = iq_head.instr;
    assign dec_pc    = iq_head.pc;
`endif

    // A bypassed word accepted by decode never enters the queue.
    assign iq_push = fire & ~(bypass & dec_ready);
    assign iq_pop  = dec_ready & ~iq_empty;

    fetch_iq #(
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (redirect_take),
        .push      (iq_push),
        .push_data ('{pc: pc_q, instr: icache.icache_load}),
        .pop       (iq_pop),
        .head      (iq_head),
        .full      (iq_full),
        .empty     (iq_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (fire)          pc_d = pc_q + 32'd4;
        if (redirect_take) pc_d = {redirect_pc[31:2], 2'b00};
        unique case (state_q)
            FETCH:   if (fire && is_halt) state_d = STOPPED;
            STOPPED: if (redirect_take)   state_d = FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
        if (core_halt) state_d = HALTED;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= {RESET_PC[31:2], 2'b00};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign icache.icache_REN  = fetch_req;
    assign icache.icache_addr = pc_q;
    // Registered by construction: HALTED is entered the edge after core_halt.
    assign icache.icache_halt = (state_q == HALTED);
    assign fetch_stopped      = (state_q == STOPPED);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import core_types_pkg::*;

    localparam int unsigned IQ_DEPTH = 4;
    localparam word_t       RESET_PC = 32'h0000_0000;
    localparam word_t       HALT     = 32'hFFFF_FFFF;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 0;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 1;
`endif

    logic  CLK = 1'b0;
    logic  RST, redirect_valid, core_halt, dec_ready;
    word_t redirect_pc;
    logic  dec_valid, fetch_stopped;
    word_t dec_instr, dec_pc;

    always #5 CLK = ~CLK;

    fetch_unit_if ic ();

    fetch_unit #(
        .IQ_DEPTH   (IQ_DEPTH),
        .RESET_PC   (RESET_PC),
        .HALT_INSTR (HALT)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .icache         (ic),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .core_halt      (core_halt),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .fetch_stopped  (fetch_stopped)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of fetched words plus a PC and two flags.
    iq_entry_t mq[$];
    word_t     m_pc;
    bit        m_stopped, m_halted;

    function automatic bit m_ren();
        return !m_halted && !m_stopped && (mq.size() < IQ_DEPTH) && !redirect_valid;
    endfunction

    function automatic bit m_byp();
        return BYP && m_ren() && ic.icache_hit && (mq.size() == 0);
    endfunction

    function automatic bit m_dvalid();
        return (mq.size() != 0) || m_byp();
    endfunction

    function automatic word_t m_dpc();
        return (mq.size() != 0) ? mq[0].pc : m_pc;
    endfunction

    function automatic word_t m_dinstr();
        return (mq.size() != 0) ? mq[0].instr : ic.icache_load;
    endfunction

    task automatic model_update();
        bit fire, byp, take;
        fire = m_ren() && ic.icache_hit;
        byp  = m_byp();
        take = m_dvalid() && dec_ready;
        if (RST) begin
            mq.delete();
            m_pc      = RESET_PC;
            m_stopped = 1'b0;
            m_halted  = 1'b0;
        end else if (redirect_valid && !core_halt && !m_halted) begin
            mq.delete();
            m_pc      = redirect_pc & ~32'h3;
            m_stopped = 1'b0;
        end else begin
            if (take && !byp) void'(mq.pop_front());
            if (fire && !(byp && dec_ready))
                mq.push_back(iq_entry_t'{pc: m_pc, instr: ic.icache_load});
            if (fire) begin
                if (ic.icache_load == HALT) m_stopped = 1'b1;
                m_pc = m_pc + 32'd4;
            end
            if (core_halt) m_halted = 1'b1;
        end
    endtask

    task automatic drive(input bit rst, input bit rv, input word_t rpc, input bit hit,
                         input word_t load, input bit rdy, input bit ch);
        RST            = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic.icache_hit  = hit;
        ic.icache_load = load;
        dec_ready      = rdy;
        core_halt      = ch;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    function automatic word_t rnd_word();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++; if (ic.icache_REN !== 1'b1) begin failures++;
            $display("FAIL reset_ren got=%b exp=1", ic.icache_REN); end
        checks++; if (dec_valid !== 1'b0) begin failures++;
            $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
        checks++; if (fetch_stopped !== 1'b0) begin failures++;
            $display("FAIL reset_stopped got=%b exp=0", fetch_stopped); end
        checks++; if (ic.icache_halt !== 1'b0) begin failures++;
            $display("FAIL reset_halt got=%b exp=0", ic.icache_halt); end
        checks++; if (ic.icache_addr !== RESET_PC) begin failures++;
            $display("FAIL reset_addr got=%h exp=%h", ic.icache_addr, RESET_PC); end
        tick();
    endtask

    task automatic test_stream();
        word_t loads[8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            loads[i] = rnd_word();
            drive(0, 0, 0, 1, loads[i], 1, 0);
            checks++; if (ic.icache_REN !== 1'b1 || ic.icache_addr !== word_t'(4 * i)) begin
                failures++;
                $display("FAIL stream_addr[%0d] got ren=%b addr=%h exp ren=1 addr=%h",
                         i, ic.icache_REN, ic.icache_addr, 4 * i);
            end
            if (i >= LAT) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== word_t'(4 * (i - LAT)) ||
                    dec_instr !== loads[i - LAT]) begin
                    failures++;
                    $display("FAIL stream_dec[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                             i, dec_valid, dec_pc, dec_instr, 4 * (i - LAT), loads[i - LAT]);
                end
            end
            tick();
        end
    endtask

    task automatic fill_four();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, rnd_word(), 0, 0);
            checks++; if (ic.icache_REN !== 1'b1 || ic.icache_addr !== word_t'(4 * i)) begin
                failures++;
                $display("FAIL fill_addr[%0d] got ren=%b addr=%h exp ren=1 addr=%h",
                         i, ic.icache_REN, ic.icache_addr, 4 * i);
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        fill_four();
        drive(0, 0, 0, 1, rnd_word(), 0, 0);
        checks++; if (ic.icache_REN !== 1'b0 || ic.icache_addr !== 32'h10) begin failures++;
            $display("FAIL full_stall got ren=%b addr=%h exp ren=0 addr=10",
                     ic.icache_REN, ic.icache_addr); end
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin failures++;
            $display("FAIL full_head got v=%b pc=%h exp v=1 pc=0", dec_valid, dec_pc); end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++; if (ic.icache_REN !== 1'b0) begin failures++;
            $display("FAIL full_pop_cycle_ren got=%b exp=0", ic.icache_REN); end
        tick();
        drive(0, 0, 0, 1, rnd_word(), 0, 0);
        checks++; if (ic.icache_REN !== 1'b1 || ic.icache_addr !== 32'h10) begin failures++;
            $display("FAIL full_resume got ren=%b addr=%h exp ren=1 addr=10",
                     ic.icache_REN, ic.icache_addr); end
        checks++; if (dec_pc !== 32'h4) begin failures++;
            $display("FAIL full_next_head got=%h exp=4", dec_pc); end
        tick();
    endtask

    task automatic test_redirect();
        fill_four();
        drive(0, 1, 32'h103, 1, rnd_word(), 0, 0);
        checks++; if (ic.icache_REN !== 1'b0) begin failures++;
            $display("FAIL redir_ren got=%b exp=0", ic.icache_REN); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (dec_valid !== 1'b0 || ic.icache_addr !== 32'h100 ||
                      ic.icache_REN !== 1'b1) begin failures++;
            $display("FAIL redir_after got v=%b addr=%h ren=%b exp v=0 addr=100 ren=1",
                     dec_valid, ic.icache_addr, ic.icache_REN); end
        tick();
        drive(0, 0, 0, 1, 32'h1234_5678, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 ||
                      dec_instr !== 32'h1234_5678) begin failures++;
            $display("FAIL redir_first got v=%b pc=%h ins=%h exp v=1 pc=100 ins=12345678",
                     dec_valid, dec_pc, dec_instr); end
        tick();
    endtask

    task automatic test_halt_instr();
        bit seen = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, (i == 2) ? HALT : rnd_word(), 1, 0);
            if (dec_valid && dec_instr == HALT && dec_pc == 32'h8) seen = 1'b1;
            if (i >= 3) begin
                checks++; if (ic.icache_REN !== 1'b0 || fetch_stopped !== 1'b1) begin
                    failures++;
                    $display("FAIL halt_stop[%0d] got ren=%b stopped=%b exp ren=0 stopped=1",
                             i, ic.icache_REN, fetch_stopped);
                end
            end
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++;
            $display("FAIL halt_to_decode got=%b exp=1", seen); end
        drive(0, 1, 32'h40, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, rnd_word(), 1, 0);
        checks++; if (ic.icache_REN !== 1'b1 || ic.icache_addr !== 32'h40 ||
                      fetch_stopped !== 1'b0) begin failures++;
            $display("FAIL halt_resume got ren=%b addr=%h stopped=%b exp ren=1 addr=40 stopped=0",
                     ic.icache_REN, ic.icache_addr, fetch_stopped); end
        tick();
    endtask

    task automatic test_core_halt();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, rnd_word(), 0, 0);
            tick();
        end
        drive(0, 1, 32'h200, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h300, 1, rnd_word(), 1, 0);
            checks++; if (ic.icache_halt !== 1'b1 || ic.icache_REN !== 1'b0 ||
                          ic.icache_addr !== 32'h8) begin failures++;
                $display("FAIL core_halt[%0d] got halt=%b ren=%b addr=%h exp halt=1 ren=0 addr=8",
                         i, ic.icache_halt, ic.icache_REN, ic.icache_addr); end
            tick();
        end
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (ic.icache_halt !== 1'b0 || ic.icache_REN !== 1'b1 ||
                      ic.icache_addr !== RESET_PC || dec_valid !== 1'b0) begin failures++;
            $display("FAIL halt_cleared got halt=%b ren=%b addr=%h v=%b exp halt=0 ren=1 addr=%h v=0",
                     ic.icache_halt, ic.icache_REN, ic.icache_addr, dec_valid, RESET_PC); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 1, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 32'h0000_0013, 0, 0);
        checks++; if (ic.icache_addr !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_pre got=%h exp=fffffffc", ic.icache_addr); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (ic.icache_addr !== 32'h0 || dec_pc !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_post got addr=%h dec_pc=%h exp addr=0 dec_pc=fffffffc",
                     ic.icache_addr, dec_pc); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, rnd_word(), 0, 0);
            tick();
        end
        drive(1, 0, 0, 1, rnd_word(), 0, 0);
        checks++; if (ic.icache_REN !== 1'b1 || ic.icache_addr !== 32'hC) begin failures++;
            $display("FAIL midrst_pre got ren=%b addr=%h exp ren=1 addr=c",
                     ic.icache_REN, ic.icache_addr); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (dec_valid !== 1'b0 || ic.icache_addr !== RESET_PC ||
                      ic.icache_REN !== 1'b1) begin failures++;
            $display("FAIL midrst_post got v=%b addr=%h ren=%b exp v=0 addr=%h ren=1",
                     dec_valid, ic.icache_addr, ic.icache_REN, RESET_PC); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(79) == 0), ($urandom_range(15) == 0), $urandom,
                  $urandom_range(1), ($urandom_range(19) == 0) ? HALT : $urandom,
                  ($urandom_range(2) != 0), ($urandom_range(299) == 0));
            checks++;
            if (ic.icache_REN !== m_ren() || (m_ren() && ic.icache_addr !== m_pc)) begin
                failures++;
                $display("FAIL rand_fetch[%0d] got ren=%b addr=%h exp ren=%b addr=%h",
                         n, ic.icache_REN, ic.icache_addr, m_ren(), m_pc);
            end
            checks++;
            if (dec_valid !== m_dvalid() ||
                (m_dvalid() && (dec_pc !== m_dpc() || dec_instr !== m_dinstr()))) begin
                failures++;
                $display("FAIL rand_dec[%0d] got v=%b pc=%h ins=%h exp v=%b pc=%h ins=%h",
                         n, dec_valid, dec_pc, dec_instr, m_dvalid(), m_dpc(), m_dinstr());
            end
            checks++;
            if (fetch_stopped !== (m_stopped && !m_halted) || ic.icache_halt !== m_halted) begin
                failures++;
                $display("FAIL rand_state[%0d] got stopped=%b halt=%b exp stopped=%b halt=%b",
                         n, fetch_stopped, ic.icache_halt, m_stopped && !m_halted, m_halted);
            end
            tick();
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        test_reset();
        test_stream();
        test_full_stall();
        test_redirect();
        test_halt_instr();
        test_core_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Core-side fetch stage directly upstream of the icache.
- Holds the PC and drives the icache's synchronous, blocking read interface (REN/addr -> hit/load).
- Buffers fetched instructions in a small instruction queue (IQ) feeding decode over a valid/ready handshake.
- Handles redirects (branch/jump resolution), detects the HALT instruction, and forwards core halt to the icache.

Parameters:
- IQ_DEPTH, 4, IQ entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- icache_REN  out  1  read request to icache.
- icache_addr  out  32  word address (word_t), bits [1:0] always 0.
- icache_halt  out  1  halt indication to icache (stops its stream buffer).
- icache_hit  in  1  icache response valid this cycle.
- icache_load  in  32  instruction word, valid when icache_hit.
- redirect_valid  in  1  PC redirect from execute/commit.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0).
- core_halt  in  1  core has committed HALT.
- dec_valid  out  1  IQ head valid to decode.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  PC of head instruction.
- dec_ready  in  1  decode accepts head this cycle.
- fetch_stopped  out  1  fetch stopped after issuing HALT_INSTR.

Behaviour:
- Reset, while RST=1 at an edge:
  - pc=RESET_PC; IQ empty (head=tail=0, count=0); state=FETCH; icache_halt=0.
  - Outputs during and after reset: icache_REN=1 (IQ not full), dec_valid=0, fetch_stopped=0.
  - Reset mid-operation discards all IQ contents and any outstanding request; no partial state survives.
- State machine, 2-bit enum:
  - FETCH: icache_REN = (count != IQ_DEPTH) & !redirect_valid; icache_addr = pc.
  - STOPPED: icache_REN=0; fetch_stopped=1.
  - HALTED: icache_REN=0; icache_halt=1.
  - FETCH->STOPPED: a hit returns icache_load == HALT_INSTR; that instruction is still pushed.
  - STOPPED->FETCH: on redirect_valid.
  - any->HALTED: on core_halt. HALTED is sticky until RST.
- Fetch: when icache_REN & icache_hit:
  - push {pc, icache_load} at tail; pc <= pc + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - Latency is set by the icache (blocking); REN and addr are held stable until the hit.
- IQ:
  - Circular buffer; pointers are $clog2(IQ_DEPTH) bits and wrap naturally; count is $clog2(IQ_DEPTH)+1 bits.
  - Full is decided on current count only. A simultaneous pop does not enable a push in the same cycle.
  - Pop when dec_valid & dec_ready.
  - Push and pop in the same cycle: count unchanged.
  - dec_valid = (count != 0). dec_instr/dec_pc come from the head entry.
- Redirect, highest priority:
  - IQ flushed next cycle (count=0); pc <= {redirect_pc[31:2], 2'b00}.
  - icache_REN forced 0 that cycle; any hit in that cycle is dropped.
  - A pop handshake in the redirect cycle still counts as accepted; decode flushes it itself.
  - Redirect has no effect in HALTED.
- core_halt and redirect_valid in the same cycle: HALTED wins.
- icache_halt is registered: asserted the cycle after core_halt is sampled.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When count==0, icache_hit=1 and state FETCH, dec_valid=1 combinationally with dec_instr=icache_load and dec_pc=pc.
  - If dec_ready, the word is consumed without entering the IQ (zero-cycle fetch-to-decode).
  - Otherwise it is pushed as normal.
  - HALT detection applies to bypassed words too.
- Undefined:
  - Minimum hit-to-dec_valid latency is 1 cycle.
  - dec_* outputs depend only on IQ registers.

Decomposition:
- core_types_pkg, shared package:
  - word_t
  - fetch_state_t {FETCH, STOPPED, HALTED}
  - iq_entry_t {pc, instr}
  - HALT_INSTR default constant
- Sub-module fetch_iq: a parameterised FIFO of iq_entry_t with push/pop/flush, full/empty, and head outputs.
- fetch_unit owns the PC, the state machine, and the bypass mux.

Test Plan:
- Reset, then icache hits every cycle, dec_ready=1: icache_addr sequence 0,4,8,…; dec_pc matches each with 1-cycle latency (0 with FETCH_BYPASS_EN).
- dec_ready=0, IQ_DEPTH=4, hits every cycle: 4 pushes, then icache_REN=0 with count=4; one pop lets REN resume the next cycle at addr 0x10.
- IQ full with addr 0x10 stalled, then redirect_valid with redirect_pc=0x103: next cycle dec_valid=0 and icache_addr=0x100; a hit during the redirect cycle is not enqueued.
- icache_load=32'hFFFF_FFFF at pc 0x8: it reaches decode; fetch_stopped=1 and REN=0; redirect to 0x40 resumes fetch at 0x40.
- core_halt pulse plus redirect_valid in the same cycle: icache_halt=1 the next cycle and stays 1; REN stays 0; a later redirect is ignored; RST clears everything.
- pc=32'hFFFF_FFFC with a hit: next icache_addr=0x0. RST asserted mid-fill with count=3: next cycle count=0 and addr=RESET_PC.
